load_store_unit: RTL and testbench

//  Multi-cycle data-memory access stage fed directly by alu_out (effective address) of the RV32I

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access stage between execute and a req/gnt/rvalid bus.
// Latency: accept at T, mem_req from T+1; zero-wait store done at T+2, load done at T+3.
// Backpressure: busy stalls the core until done; mem_* held stable while mem_gnt is low.
//
// Optional build macro: LSU_MISALIGN_FAULT_EN
//   defined   -> misaligned / illegal ops skip the bus and complete with done+fault.
//   undefined -> offsets forced to natural alignment, illegal load funct3 acts as LW,
//                fault tied 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   valid_i               memory op present (inputs held stable while busy)
//   is_load, is_store     op kind; store wins if both set
//   funct3                RV32I width/sign code
//   addr, store_data      effective address and LSB-justified rs2 value
//   busy                  combinational stall request to the core
//   done, fault           one-cycle completion pulse / fault flag
//   load_data             extended load result, held until the next load completes
//   mem_req/we/addr/be/wdata  bus request outputs
//   mem_gnt, mem_rvalid, mem_rdata  bus responses
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             is_load,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] load_data,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             accept;
  logic             sz_b, sz_h;
  logic [1:0]       off_nxt;
  logic [3:0]       be_nxt;
  logic [WIDTH-1:0] wdata_nxt;
  logic [WIDTH-1:0] rdata_sh;
  logic [WIDTH-1:0] ld_ext;
  logic             op_bad;

  assign busy   = valid_i & (is_load | is_store) & ~done;
  assign accept = (state == IDLE) & valid_i & (is_load | is_store);

  // Access size from funct3[1:0]; 10 and 11 both behave as a word.
  assign sz_b = (funct3[1:0] == 2'b00);
  assign sz_h = (funct3[1:0] == 2'b01);

  // Lane offset snapped to natural alignment. In the fault build any op whose
  // raw offset differs from this never reaches the bus, so one path serves both.
  assign off_nxt = sz_b ? addr[1:0] : (sz_h ? {addr[1], 1'b0} : 2'b00);

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = store_data;
    if (sz_b) begin
      wdata_nxt = {4{store_data[7:0]}};
      if (is_store) be_nxt = 4'b0001 << off_nxt;
    end else if (sz_h) begin
      wdata_nxt = {2{store_data[15:0]}};
      if (is_store) be_nxt = 4'b0011 << off_nxt;
    end
  end

`ifdef LSU_MISALIGN_FAULT_EN
  logic fault_q;

  assign op_bad = (sz_h & addr[0])
                | (~sz_b & ~sz_h & (addr[1:0] != 2'b00))
                | (~is_store & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)));

  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= accept & op_bad;
  end

  assign fault = fault_q;
`else
  assign op_bad = 1'b0;
  assign fault  = 1'b0;
`endif

  // Bring the addressed byte/half down to bit 0 before extension.
  assign rdata_sh = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b100:  ld_ext = {24'd0, rdata_sh[7:0]};
      3'b001:  ld_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b101:  ld_ext = {16'd0, rdata_sh[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = op_bad ? DONE : REQ;
      REQ:  if (mem_gnt) next_state = mem_we ? DONE : WAIT;
      WAIT: if (mem_rvalid) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      load_data <= '0;
      done      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
    end else begin
      state   <= next_state;
      mem_req <= (next_state == REQ);
      done    <= (next_state == DONE);
      if (accept) begin
        mem_we    <= is_store;
        mem_addr  <= {addr[WIDTH-1:2], 2'b00};
        mem_be    <= be_nxt;
        mem_wdata <= wdata_nxt;
        f3_q      <= funct3;
        off_q     <= off_nxt;
      end
      if ((state == WAIT) && mem_rvalid) load_data <= ld_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

`ifdef LSU_MISALIGN_FAULT_EN
  localparam bit FAULT_BUILD = 1'b1;
`else
  localparam bit FAULT_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, store_data = '0;
  logic        busy, done, fault, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_ld = '0;

  load_store_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes for a funct3 code; anything unnamed counts as a word.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] rd,
                                           input int off, input int n);
    longint v, span;
    span = longint'(1) << (8 * n);
    v = (longint'(rd) >> (8 * off)) % span;
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic run_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                        input int gdly, input int rdly);
    int n, ao, off, exp_done, reqs, done_at, gnt_at, extra;
    bit bad, unstable, busy_bad, f_seen;
    logic [3:0]  e_be, s_be;
    logic [31:0] e_wd, e_ld, s_addr, s_wd;
    logic        s_we;
    n   = size_of(f3);
    ao  = int'(a % 4);
    off = ao - (ao % n);
    bad = FAULT_BUILD && ((n == 2 && ao % 2 != 0) || (n == 4 && ao != 0) ||
                          (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)));
    e_be = st ? 4'(((1 << n) - 1) << off) : 4'hF;
    for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = sd[8*(i % n) +: 8];
    e_ld = load_ext(f3, rd, off, n);
    exp_done = bad ? 1 : (st ? 2 + gdly : 3 + gdly + rdly);

    @(negedge clk);
    valid_i = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    reqs = 0; done_at = -1; gnt_at = -1; unstable = 0; busy_bad = 0; f_seen = 0;
    s_addr = '0; s_be = '0; s_wd = '0; s_we = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (busy !== !done) busy_bad = 1;
      if (mem_req === 1'b1) begin
        reqs++;
        if (reqs == 1) begin
          s_addr = mem_addr; s_be = mem_be; s_wd = mem_wdata; s_we = mem_we;
        end else if (mem_addr !== s_addr || mem_be !== s_be || mem_wdata !== s_wd ||
                     mem_we !== s_we) begin
          unstable = 1;
        end
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (done === 1'b1) begin
        done_at = cyc; f_seen = fault;
        check({tag, " load_data"}, load_data, (!bad && !st) ? e_ld : last_ld);
        break;
      end
      if (mem_req === 1'b1 && reqs == gdly + 1) begin mem_gnt = 1'b1; gnt_at = cyc; end
      if (!st && gnt_at > 0 && cyc == gnt_at + 1 + rdly) begin
        mem_rvalid = 1'b1; mem_rdata = rd;
      end
    end
    valid_i = 1'b0; is_load = 1'b0; is_store = 1'b0;
    if (!bad && !st) last_ld = e_ld;

    check({tag, " done_cycle"}, done_at, exp_done);
    check({tag, " fault"}, f_seen, bad);
    check({tag, " busy"}, busy_bad, 0);
    if (bad) begin
      check({tag, " req_count"}, reqs, 0);
    end else begin
      check({tag, " req_count"}, reqs, gdly + 1);
      check({tag, " mem_addr"}, s_addr, {a[31:2], 2'b00});
      check({tag, " mem_we"}, s_we, st);
      check({tag, " mem_be"}, s_be, e_be);
      check({tag, " stable"}, unstable, 0);
      if (st) check({tag, " mem_wdata"}, s_wd, e_wd);
    end
    extra = 0;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) extra++;
    end
    check({tag, " extra_done"}, extra, 0);
  endtask

  initial begin
    int rd_dly;
    bit st, ld;
    logic [2:0] f3;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst done", done, 0);
    check("rst fault", fault, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_be", mem_be, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst load_data", load_data, 0);
    check("rst busy", busy, 0);
    reset = 1'b0;

    // valid_i without a memory op must neither stall nor request.
    @(negedge clk);
    valid_i = 1'b1;
    repeat (2) @(negedge clk);
    check("nop busy", busy, 0);
    check("nop mem_req", mem_req, 0);
    valid_i = 1'b0;

    // Directed cases.
    run_op("sw",  0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    run_op("lb",  1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0, 0);
    run_op("lbu", 1, 0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0, 0);
    run_op("lh",  1, 0, 3'b001, 32'h202, 32'h0, 32'h80017FFF, 0, 0);
    run_op("sh",  0, 1, 3'b001, 32'h202, 32'h1234, 32'h0, 0, 0);
    run_op("slow_lw", 1, 0, 3'b010, 32'h40, 32'h0, 32'hA5A55A5A, 3, 2);

    // Reset while waiting for read data abandons the load.
    @(negedge clk);
    valid_i = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    check("rstwait req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; valid_i = 1'b0; is_load = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    check("rstwait mem_req", mem_req, 0);
    check("rstwait done0", done, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rstwait done1", done, 0);
    check("rstwait load_data", load_data, 0);
    check("rstwait mem_req1", mem_req, 0);
    last_ld = '0;
    run_op("after_rst", 1, 0, 3'b010, 32'h304, 32'h0, 32'h13579BDF, 1, 1);

    // Misaligned word load: fault build skips the bus, default build aligns.
    run_op("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0);

    // Randomized ops.
    for (int k = 0; k < 40; k++) begin
      st = 1'($urandom_range(0, 1));
      ld = !st || ($urandom_range(0, 3) == 0);
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      rd_dly = $urandom_range(0, 3);
      run_op($sformatf("rnd%0d", k), ld, st, f3, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), rd_dly);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
